// File: rtl/ccsm_pkg.sv
// Shared types and default sizing for the ccsm input conditioner.
package ccsm_pkg;

  // Per-channel debounce state.
  typedef enum logic {STABLE, PENDING} deb_state_e;

  localparam int unsigned CCSM_N_IN            = 3;
  localparam int unsigned CCSM_SYNC_STAGES     = 2;
  localparam int unsigned CCSM_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/ccsm_debounce_ch.sv
// One input channel: synchroniser chain, debounce FSM with persistence counter,
// and registered rise/fall strobes.
module ccsm_debounce_ch
  import ccsm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = CCSM_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = CCSM_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept   // clean will change on the next rising edge
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   clean_q;
  logic                   rise_q;
  logic                   fall_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw level through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Decide whether the synchronised level has persisted long enough to be taken.
  always_comb begin
    accept = 1'b0;
    if (s != clean_q) begin
      if (state_q == STABLE) begin
        accept = (DEBOUNCE_CYCLES == 1);
      end else begin
        accept = (cnt_q == CNT_MAX);
      end
    end
  end

  // Debounce FSM, counter, clean level and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (accept) begin
        clean_q <= s;
        rise_q  <= s;
        fall_q  <= ~s;
        cnt_q   <= '0;
        state_q <= STABLE;
      end else begin
        unique case (state_q)
          STABLE: begin
            if (s != clean_q) begin
              state_q <= PENDING;
              cnt_q   <= CNT_W'(1);
            end
          end
          PENDING: begin
            if (s == clean_q) begin
              // Bounce back to the accepted level: drop the candidate.
              state_q <= STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ccsm_input_conditioner.sv
// Front end for the ccsm logic block: synchronises and debounces N_IN raw
// inputs and reports per-bit edges plus a single "something changed" pulse.
module ccsm_input_conditioner
  import ccsm_pkg::*;
#(
  parameter int unsigned N_IN            = CCSM_N_IN,
  parameter int unsigned SYNC_STAGES     = CCSM_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = CCSM_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sw_raw,
  output logic [N_IN-1:0] sw_clean,
  output logic [N_IN-1:0] sw_rise,
  output logic [N_IN-1:0] sw_fall,
  output logic            upd
);

  logic [N_IN-1:0] accept;
  logic            upd_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    ccsm_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_raw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .accept(accept[i])
    );
  end

  // Registered so it lines up with the channel strobes rather than ORing them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= |accept;
    end
  end

  assign upd = upd_q;

endmodule

// File: tb/tb_ccsm_input_conditioner.sv
// Scoreboard bench for ccsm_input_conditioner at DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_ccsm_input_conditioner;

  localparam int unsigned LAT = 6;  // sync stages + debounce cycles

  typedef struct {
    int         cyc;
    logic [2:0] clean;
    logic [2:0] rise;
    logic [2:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw_raw = 3'b000;
  logic [2:0] sw_clean, sw_rise, sw_fall;
  logic       upd;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];
  logic [2:0] model_clean = 3'b000;
  logic       rst_at_edge = 1'b0;

  ccsm_input_conditioner #(
    .N_IN           (3),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect an upd pulse LAT edges after the raw change just driven.
  task automatic expect_upd(input logic [2:0] c, input logic [2:0] r, input logic [2:0] f);
    exp_t e;
    e.cyc   = cyc + LAT;
    e.clean = c;
    e.rise  = r;
    e.fall  = f;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on every upd, and track the clean level between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) model_clean = 3'b000;
    if (upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_upd", 32'(sw_clean), 32'(model_clean));
        total++;
        bad++;
        $display("FAIL unexpected_upd: got upd=1 required no pulse (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("upd_cycle", 32'(cyc), 32'(e.cyc));
        check("upd_clean", 32'(sw_clean), 32'(e.clean));
        check("upd_rise", 32'(sw_rise), 32'(e.rise));
        check("upd_fall", 32'(sw_fall), 32'(e.fall));
        model_clean = e.clean;
      end
    end else begin
      check("clean_hold", 32'(sw_clean), 32'(model_clean));
    end
    check("upd_vs_strobes", 32'(upd), 32'(|(sw_rise | sw_fall)));
  end

  initial begin
    // 1: reset with inputs high, then full re-qualification
    rst_n  = 1'b0;
    sw_raw = 3'b111;
    tick(3);
    check("rst_clean", 32'(sw_clean), 32'd0);
    check("rst_rise", 32'(sw_rise), 32'd0);
    check("rst_fall", 32'(sw_fall), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    rst_n = 1'b1;
    expect_upd(3'b111, 3'b111, 3'b000);
    tick(10);
    sw_raw = 3'b000;
    expect_upd(3'b000, 3'b000, 3'b111);
    tick(10);

    // 2: clean step on bit 2
    sw_raw = 3'b100;
    expect_upd(3'b100, 3'b100, 3'b000);
    tick(10);

    // 3: bounce on bit 0: 3 high, 2 low, then hold high
    sw_raw = 3'b101;
    tick(3);
    sw_raw = 3'b100;
    tick(2);
    sw_raw = 3'b101;
    expect_upd(3'b101, 3'b001, 3'b000);
    tick(10);

    // 4: 3-cycle pulse rejected, 4-cycle pulse accepted then released
    sw_raw = 3'b111;
    tick(3);
    sw_raw = 3'b101;
    tick(8);
    sw_raw = 3'b111;
    expect_upd(3'b111, 3'b010, 3'b000);
    tick(4);
    sw_raw = 3'b101;
    expect_upd(3'b101, 3'b000, 3'b010);
    tick(10);
    sw_raw = 3'b000;
    expect_upd(3'b000, 3'b000, 3'b101);
    tick(10);

    // 5: two channels rise on the same edge
    sw_raw = 3'b011;
    expect_upd(3'b011, 3'b011, 3'b000);
    tick(10);
    sw_raw = 3'b000;
    expect_upd(3'b000, 3'b000, 3'b011);
    tick(10);

    // 6: reset two edges before bit 1 would qualify
    sw_raw = 3'b010;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("midpend_rst_clean", 32'(sw_clean), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("midpend_after_clean", 32'(sw_clean), 32'd0);
    exp_q.push_back('{cyc: cyc - 2 + LAT, clean: 3'b010, rise: 3'b010, fall: 3'b000});
    tick(12);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
